// File: rtl/rotate_coef_arb.sv
// rotate_coef_arb: round-robin 2-requester angle arbiter; reads sin/cos from an external 360-entry table and returns signed 10-bit coefficients.
module rotate_coef_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [8:0] req0_angle,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [8:0] req1_angle,
  output logic       req1_ready,
  output logic       rom_rd_en,
  output logic [8:0] rom_addr,
  input  logic [8:0] rom_dout,
  output logic       coef_valid,
  input  logic       coef_ready,
  output logic       coef_id,
  output logic [9:0] coef_sin,
  output logic [9:0] coef_cos
);
  typedef enum logic [2:0] {IDLE, RD_SIN, RD_COS, CAP, OUT} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d, id_q, id_d;
  logic [8:0] a_q, a_d, c, ang;
  logic [9:0] sin_q, sin_d, cos_q, cos_d;
  assign req0_ready = state_q == IDLE && req0_valid && (!prio_q || !req1_valid);
  assign req1_ready = state_q == IDLE && req1_valid && (prio_q || !req0_valid);
  assign ang = req1_ready ? req1_angle : req0_angle;
  assign c = a_q < 9'd270 ? a_q + 9'd90 : a_q - 9'd270;
  assign coef_id = id_q;
  assign coef_sin = sin_q;
  assign coef_cos = cos_q;
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    id_d = id_q;
    a_d = a_q;
    sin_d = sin_q;
    cos_d = cos_q;
    rom_rd_en = 1'b0;
    rom_addr = 9'd0;
    coef_valid = 1'b0;
    case (state_q)
      IDLE: if (req0_ready || req1_ready) begin
        state_d = RD_SIN;
        id_d = req1_ready;
        prio_d = !req1_ready;
        a_d = ang >= 9'd360 ? ang - 9'd360 : ang;
      end
      RD_SIN: begin
        rom_rd_en = 1'b1;
        rom_addr = a_q;
        state_d = RD_COS;
      end
      RD_COS: begin
        rom_rd_en = 1'b1;
        rom_addr = c;
        sin_d = {a_q >= 9'd181, rom_dout};
        state_d = CAP;
      end
      CAP: begin
        cos_d = {c >= 9'd181, rom_dout};
        state_d = OUT;
      end
      OUT: begin
        coef_valid = 1'b1;
        state_d = coef_ready ? IDLE : OUT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      id_q <= 1'b0;
      a_q <= 9'd0;
      sin_q <= 10'd0;
      cos_q <= 10'd0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      id_q <= id_d;
      a_q <= a_d;
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end
endmodule
